// File: rtl/kronos_types.sv
// kronos_types
// Shared types for the Kronos write-back stage.
//   pipeEXWB_t     : bundle handed from EX to WB
//   wb_state_e     : write-back FSM states (IDLE, LOAD, STORE)
//   BYTE/HALF/WORD : data_size encodings
//   is_misaligned  : true when a halfword/word access does not sit on its natural boundary
package kronos_types;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic        ld;
    logic        st;
    logic [1:0]  data_size;
    logic        data_uns;
    logic        illegal;
    logic [31:0] result1;
    logic [31:0] result2;
  } pipeEXWB_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } wb_state_e;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  // Bytes never straddle, halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic result;
    result = 1'b0;
    if (size == HALF) begin
      result = addr_lo[0];
    end else if (size != BYTE) begin
      result = (addr_lo != 2'b00);
    end
    return result;
  endfunction

endpackage

// File: rtl/kronos_lsu_align.sv
// kronos_lsu_align
// Combinational byte-lane steering for the load/store unit.
//   addr_lo     in  2   byte offset inside the 32-bit word
//   size        in  2   BYTE/HALF/WORD
//   uns         in  1   zero-extend loads when set
//   store_data  in  32  store data, right-aligned
//   load_raw    in  32  raw word returned by the bus
//   mask        out 4   byte enables (lanes beyond bit 31 are dropped)
//   store_lane  out 32  store data shifted into its lane
//   load_data   out 32  load value extracted and sign/zero-extended
module kronos_lsu_align
  import kronos_types::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  mask,
  output logic [31:0] store_lane,
  output logic [31:0] load_data
);

  logic [4:0]  shift;
  logic [3:0]  base_mask;
  logic [31:0] load_shifted;

  // Shift amounts are byte offsets times eight; shifting a 4-bit mask left
  // naturally truncates lanes that would fall past the top of the word.
  always_comb begin
    shift        = {addr_lo, 3'b000};
    base_mask    = 4'b1111;
    if (size == BYTE) begin
      base_mask = 4'b0001;
    end else if (size == HALF) begin
      base_mask = 4'b0011;
    end
    mask         = base_mask << addr_lo;
    store_lane   = store_data << shift;
    load_shifted = load_raw >> shift;
    case (size)
      BYTE:    load_data = {{24{~uns & load_shifted[7]}}, load_shifted[7:0]};
      HALF:    load_data = {{16{~uns & load_shifted[15]}}, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
  end

endmodule

// File: rtl/kronos_wb_stage.sv
// kronos_wb_stage
// Write-back stage: commits ALU results, performs loads/stores on the data
// bus, redirects fetch on taken branches/jumps and flags illegal instructions.
// Optional macro: KRONOS_WB_MISALIGN_TRAP_EN -- misaligned halfword/word
// accesses trap instead of being issued to the bus.
// Ports:
//   clk, rst                  clock, async active-high reset
//   execute, pipe_in_vld/rdy  EX->WB bundle and handshake
//   regwr_data/sel/en         register-file write (also EX forwarding)
//   branch_target, branch     fetch redirect
//   data_addr/wr_data/mask/wr_en/req, data_rd_data/ack   data bus
//   trap                      illegal or misaligned strobe
module kronos_wb_stage
  import kronos_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  pipeEXWB_t   execute,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic [31:0] regwr_data,
  output logic [4:0]  regwr_sel,
  output logic        regwr_en,
  output logic [31:0] branch_target,
  output logic        branch,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic [31:0] data_rd_data,
  input  logic        data_ack,
  output logic        trap
);

  wb_state_e   state, state_next;
  logic        accept;
  logic        misalign;
  logic        bad_instr;
  logic [1:0]  off_q, size_q;
  logic        uns_q, rd_write_q;
  logic [4:0]  rd_q;
  logic [1:0]  align_off, align_size;
  logic        align_uns;
  logic [3:0]  align_mask;
  logic [31:0] align_store, align_load;

  assign pipe_in_rdy = (state == IDLE);
  assign accept      = pipe_in_vld & pipe_in_rdy;

`ifdef KRONOS_WB_MISALIGN_TRAP_EN
  assign misalign = (execute.ld | execute.st) & is_misaligned(execute.data_size, execute.result1[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign bad_instr = execute.illegal | misalign;

  // While idle the aligner looks at the incoming instruction (mask/store lane);
  // while a load is outstanding it uses the captured offset to extract the reply.
  assign align_off  = (state == IDLE) ? execute.result1[1:0] : off_q;
  assign align_size = (state == IDLE) ? execute.data_size    : size_q;
  assign align_uns  = (state == IDLE) ? execute.data_uns     : uns_q;

  kronos_lsu_align u_align (
    .addr_lo    (align_off),
    .size       (align_size),
    .uns        (align_uns),
    .store_data (execute.result2),
    .load_raw   (data_rd_data),
    .mask       (align_mask),
    .store_lane (align_store),
    .load_data  (align_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Illegal/misaligned instructions never leave IDLE; bus operations wait for ack.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !bad_instr) begin
          if (execute.ld) begin
            state_next = LOAD;
          end else if (execute.st) begin
            state_next = STORE;
          end
        end
      end
      LOAD, STORE: begin
        if (data_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs. Strobes default low every cycle so they only ever pulse;
  // bus request/address/mask are held until the acknowledging cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_data    <= '0;
      regwr_sel     <= '0;
      regwr_en      <= 1'b0;
      branch_target <= '0;
      branch        <= 1'b0;
      data_addr     <= '0;
      data_wr_data  <= '0;
      data_mask     <= '0;
      data_wr_en    <= 1'b0;
      data_req      <= 1'b0;
      trap          <= 1'b0;
      off_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      rd_q          <= '0;
      rd_write_q    <= 1'b0;
    end else begin
      regwr_en <= 1'b0;
      branch   <= 1'b0;
      trap     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bad_instr) begin
              trap <= 1'b1;
            end else if (execute.ld || execute.st) begin
              data_req   <= 1'b1;
              data_wr_en <= execute.st & ~execute.ld;
              data_addr  <= {execute.result1[31:2], 2'b00};
              data_mask  <= align_mask;
              if (!execute.ld) begin
                data_wr_data <= align_store;
              end
              off_q      <= execute.result1[1:0];
              size_q     <= execute.data_size;
              uns_q      <= execute.data_uns;
              rd_q       <= execute.rd;
              rd_write_q <= execute.rd_write;
            end else begin
              regwr_en      <= execute.rd_write & (execute.rd != 5'd0);
              regwr_sel     <= execute.rd;
              regwr_data    <= execute.result1;
              branch        <= execute.branch | (execute.branch_cond & execute.result1[0]);
              branch_target <= execute.result2;
            end
          end
        end
        LOAD: begin
          if (data_ack) begin
            data_req   <= 1'b0;
            regwr_en   <= rd_write_q & (rd_q != 5'd0);
            regwr_sel  <= rd_q;
            regwr_data <= align_load;
          end
        end
        STORE: begin
          if (data_ack) begin
            data_req <= 1'b0;
          end
        end
        default: data_req <= 1'b0;
      endcase
    end
  end

endmodule
